// File: rtl/led_pattern_sequencer_pkg.sv
// Shared mode encodings for the LED pattern sequencer and anything that drives its mode port.
package led_pattern_sequencer_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

endpackage

// File: rtl/led_pattern_sequencer_tick_prescaler.sv
// Free-running modulo-TICK_DIVIDER counter; tick is high in the last count of each period.
module tick_prescaler #(
  parameter int TICK_DIVIDER = 8
) (
  input  logic clk_ext,
  input  logic reset,
  output logic tick
);

  localparam int                CNT_W = $clog2(TICK_DIVIDER);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIVIDER - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: the default assignment at the top of always_comb keeps every path driven, so no latch.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  assign tick = (cnt_q == LAST);

  // NOTE: flops use <= so all registers update together from pre-edge values.
  always_ff @(posedge clk_ext) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern generator: mode handshake, pending-mode register, mode FSM and LED datapath.
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int NUM_LEDS     = 4,
  parameter int TICK_DIVIDER = 8
) (
  input  logic                clk_ext,
  input  logic                reset,
  input  logic [MODE_W-1:0]   mode,
  input  logic                mode_valid,
  output logic                mode_ready,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_strobe
);

  logic                tick;
  logic                transfer;
  logic                apply;

  logic                pend_valid_q, pend_valid_d;
  mode_e               pend_mode_q,  pend_mode_d;
  mode_e               mode_q,       mode_d;
  logic [NUM_LEDS-1:0] led_q,        led_d;
  logic                strobe_q,     strobe_d;

  tick_prescaler #(
    .TICK_DIVIDER (TICK_DIVIDER)
  ) u_prescaler (
    .clk_ext (clk_ext),
    .reset   (reset),
    .tick    (tick)
  );

  // The pending register only fills from the cycle after the transfer, so a transfer
  // coinciding with a tick naturally waits for the following tick.
  assign mode_ready = ~pend_valid_q;
  assign transfer   = mode_valid & ~pend_valid_q;
  assign apply      = tick & pend_valid_q;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_mode_d  = pend_mode_q;
    if (apply) begin
      pend_valid_d = 1'b0;
    end else if (transfer) begin
      pend_valid_d = 1'b1;
      pend_mode_d  = mode_e'(mode);
    end
  end

  // Mode FSM next state: only an applying tick moves it.
  always_comb begin
    mode_d = mode_q;
    if (apply) mode_d = pend_mode_q;
  end

  // LED datapath: restart value on apply, otherwise continue the active pattern.
  always_comb begin
    led_d    = led_q;
    strobe_d = tick;
    if (tick) begin
      if (apply) begin
        case (mode_d)
          MODE_WALK:  led_d = NUM_LEDS'(1);
          MODE_BLINK: led_d = '1;
          MODE_COUNT: led_d = NUM_LEDS'(1);
          default:    led_d = '0;
        endcase
      end else begin
        case (mode_d)
          MODE_WALK:  led_d = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
          MODE_BLINK: led_d = ~led_q;
          MODE_COUNT: led_d = led_q + NUM_LEDS'(1);
          default:    led_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_ext) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_mode_q  <= MODE_OFF;
      mode_q       <= MODE_OFF;
      led_q        <= '0;
      strobe_q     <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_mode_q  <= pend_mode_d;
      mode_q       <= mode_d;
      led_q        <= led_d;
      strobe_q     <= strobe_d;
    end
  end

  assign led         = led_q;
  assign step_strobe = strobe_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised scoreboard bench for led_pattern_sequencer (NUM_LEDS=4, TICK_DIVIDER=4).
module tb_led_pattern_sequencer;
  import led_pattern_sequencer_pkg::*;

  localparam int NL  = 4;
  localparam int TD  = 4;
  localparam int ALL = (1 << NL) - 1;

  logic          clk_ext    = 1'b0;
  logic          reset      = 1'b1;
  logic          mode_valid = 1'b0;
  logic [1:0]    mode       = 2'd0;
  logic          mode_ready;
  logic [NL-1:0] led;
  logic          step_strobe;

  always #5 clk_ext = ~clk_ext;

  led_pattern_sequencer #(
    .NUM_LEDS     (NL),
    .TICK_DIVIDER (TD)
  ) dut (
    .clk_ext     (clk_ext),
    .reset       (reset),
    .mode        (mode),
    .mode_valid  (mode_valid),
    .mode_ready  (mode_ready),
    .led         (led),
    .step_strobe (step_strobe)
  );

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int exp_total  = 0;
  int seen_total = 0;
  int hold_led   = 0;
  bit hold_ok    = 1'b0;

  // Reference model: cycle index since reset, pending slot, active mode, steps since apply.
  int m_k         = 0;
  bit m_pend      = 1'b0;
  int m_pend_mode = 0;
  int m_mode      = 0;
  int m_n         = 0;

  function automatic int pattern(int md, int n);
    case (md)
      1:       return 1 << (n % NL);
      2:       return (n % 2 == 0) ? ALL : 0;
      3:       return (n + 1) % (1 << NL);
      default: return 0;
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k     = 0;
    m_pend  = 1'b0;
    m_mode  = 0;
    m_n     = 0;
    hold_ok = 1'b0;
  endtask

  // Drive one cycle's inputs at the falling edge and advance the model over that cycle.
  task automatic cycle(bit rst, bit v, int md);
    bit tick, xfer;
    @(negedge clk_ext);
    reset      = rst;
    mode_valid = v;
    mode       = 2'(md);
    if (rst) begin
      model_reset();
    end else begin
      check("mode_ready", int'(mode_ready), int'(!m_pend));
      tick = (m_k % TD == TD - 1);
      xfer = v && !m_pend;
      if (tick) begin
        if (m_pend) begin
          m_mode = m_pend_mode;
          m_n    = 0;
          m_pend = 1'b0;
        end else begin
          m_n++;
        end
        exp_q.push_back(pattern(m_mode, m_n));
        exp_total++;
      end
      if (xfer) begin
        m_pend      = 1'b1;
        m_pend_mode = md;
      end
      m_k++;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0);
  endtask

  task automatic send(int md);
    while (m_pend) cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, md);
  endtask

  // Reset only in a cycle with no strobe in flight, then confirm the cleared outputs.
  task automatic do_reset();
    while (m_k % TD != 1) cycle(1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);
    check("reset_led", int'(led), 0);
    check("reset_strobe", int'(step_strobe), 0);
    check("reset_queue", exp_q.size(), 0);
  endtask

  // Monitor: every strobe must match the next scoreboard entry; led must hold between strobes.
  always @(negedge clk_ext) begin
    if (step_strobe) begin
      seen_total++;
      if (exp_q.size() == 0) begin
        check("strobe_unexpected", 1, 0);
      end else begin
        hold_led = exp_q.pop_front();
        check("led_step", int'(led), hold_led);
        hold_ok = 1'b1;
      end
    end else if (hold_ok && !reset) begin
      check("led_hold", int'(led), hold_led);
    end
  end

  initial begin
    #2_000_000;
    check("watchdog", 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    idle(1);
    check("init_led", int'(led), 0);
    check("init_ready", int'(mode_ready), 1);
    idle(12);

    send(MODE_WALK);   idle(22);
    send(MODE_COUNT);  idle(70);
    send(MODE_BLINK);  idle(14);

    // Transfer in a tick cycle: applied one full period later.
    while (m_pend || (m_k % TD != TD - 1)) cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, MODE_WALK);
    idle(10);

    // mode_valid held high: one transfer per apply.
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1, $urandom_range(0, 3));
    idle(8);

    // Reset mid-WALK with BLINK pending.
    send(MODE_WALK); idle(10);
    while (m_pend || (m_k % TD != 0)) cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, MODE_BLINK);
    do_reset();
    idle(16);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 3));
    end

    idle(6);
    check("queue_drain", exp_q.size(), 0);
    check("strobe_count", seen_total, exp_total);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
